input_pad_stream: RTL and testbench
===================================

// Module: input_pad_stream
// PURPOSE
//  Streaming successor to the array-based input padder. Accepts one CHANNELS-wide pixel per beat in raster
//  order over valid/ready, emits a frame padded right/bottom to the next multiple of FILTER_SIZE.
//  Pad pixels are zero/constant or edge-replicated. Sits between the input feature-map source and the
//  conv window generator; replaces full-frame array ports with a stream (no frame storage, one line buffer).
// PARAMETERS
//  DATA_W       32  bits per channel lane
//  IN_W         7   input columns (>=1)
//  IN_H         7   input rows (>=1)
//  FILTER_SIZE  3   pad target; OUT_W=IN_W+((FILTER_SIZE-IN_W%FILTER_SIZE)%FILTER_SIZE), OUT_H likewise from IN_H
//  CHANNELS     1   lanes per beat, lane c = data[c*DATA_W +: DATA_W]
//  PAD_MODE     0   0 = constant PAD_VALUE; 1 = replicate nearest edge pixel
//  PAD_VALUE    0   DATA_W constant used per lane when PAD_MODE=0
// PORTS
//  clk        in   1                single clock, all state on posedge
//  reset      in   1                asynchronous, active-low; clears all state
//  en         in   1                start in IDLE; 0 mid-frame pauses (no beat accepted/launched)
//  in_valid   in   1                input beat valid
//  in_ready   out  1                input beat accepted when in_valid&in_ready
//  in_data    in   CHANNELS*DATA_W  input pixel
//  out_valid  out  1                output beat valid
//  out_ready  in   1                downstream accept
//  out_data   out  CHANNELS*DATA_W  output pixel (registered)
//  out_eol    out  1                with out_data: last column of a row (col==OUT_W-1)
//  out_eof    out  1                with out_data: last beat of frame
//  busy       out  1                FSM not IDLE
//  frame_done out  1                1-cycle pulse when final beat handshakes on out
// BEHAVIOUR
//  Reset (reset=0): out_valid=0, out_data=0, out_eol=0, out_eof=0, in_ready=0, busy=0, frame_done=0,
//   row/col=0, FSM=IDLE, line buffer contents don't-care. Async assert, sync-safe deassert.
//  Output stage: single register; loads when (!out_valid || out_ready) && en ("adv"). out_valid, out_data,
//   out_eol, out_eof held stable while out_valid && !out_ready. Latency in->out = 1 cycle.
//  FSM:
//   IDLE    : in_ready=0; en=1 -> PASS (row=col=0).
//   PASS    : in_ready=adv. Each accepted beat -> out reg, col++. At col==IN_W-1:
//             OUT_W>IN_W -> PAD_COL; else end-of-row.
//   PAD_COL : in_ready=0; each adv emits pad beat (PAD_VALUE, or last accepted pixel of row held
//             in edge reg); col++ until col==OUT_W-1 -> end-of-row.
//   end-of-row: col=0; row<IN_H-1 -> row++, PASS; row==IN_H-1 and OUT_H>IN_H -> row++, PAD_ROW; else DRAIN.
//   PAD_ROW : in_ready=0; each adv emits beat; mode 1 = line_buf[col] (row IN_H-1 incl. its pad cols,
//             written on every out-reg load of that row); col wraps OUT_W-1->0, row++; last -> DRAIN.
//   DRAIN   : wait for final beat (out_eof) to handshake; pulse frame_done; -> IDLE.
//  Beat count per frame exactly OUT_W*OUT_H; out_eof only on row==OUT_H-1, col==OUT_W-1.
//  Aligned case (IN_W,IN_H multiples of FILTER_SIZE): pure pass-through, PAD_COL/PAD_ROW never entered.
//  en=0 mid-frame: FSM, counters frozen; in_ready=0; pending out beat held (out_valid stays 1).
//  Extra input after last input pixel is not accepted until next frame start (in_ready=0).
//  Next frame starts only from IDLE with en=1; back-to-back frames allowed (IDLE lasts 1 cycle).
//  Counters sized $clog2(OUT_W+1), $clog2(OUT_H+1); line buffer OUT_W x CHANNELS*DATA_W, only if PAD_MODE=1.
//  Lanes processed identically and independently; no arithmetic on data.
// TESTING
//  1 Defaults, 7x7 of 3s, PAD_MODE=0, out_ready=1 -> 81 beats; (r<7&&c<7)=3 else 0; eol at c=8; eof beat 81.
//  2 PAD_MODE=1, pixel=r*16+c -> out[r][c]=in[min(r,6)][min(c,6)]; out[8][8]=0x66, out[2][8]=0x26.
//  3 IN_W=IN_H=6 -> 36 beats bit-identical to input, PAD states never visited, frame_done once.
//  4 Random in_valid/out_ready (50%) -> same 81-beat sequence as test 1; out beat stable while stalled.
//  5 reset low at beat 40, then restart frame -> all outputs 0 during reset; full correct 81 beats after.
//  6 CHANNELS=2, lane0=3, lane1=r*9+c, PAD_MODE=1, en low 10 cycles mid-row -> lanes correct, no beat lost.

Source files
------------

// File: rtl/input_pad_stream.sv
// ----------------------------------------------------------------------------
// input_pad_stream
//   Streaming input padder. Accepts one CHANNELS-wide pixel per beat in raster
//   order and emits a frame padded on the right and bottom up to the next
//   multiple of FILTER_SIZE. Pad pixels are either a constant (PAD_MODE=0) or
//   a replica of the nearest edge pixel (PAD_MODE=1). No frame storage: one
//   edge register plus one line buffer (last input row) in replicate mode.
//
// Ports
//   clk        : clock, all state on posedge
//   reset      : asynchronous active-low reset
//   en         : starts a frame from IDLE; low mid-frame pauses everything
//   in_valid   : input beat valid
//   in_ready   : input beat accepted when in_valid & in_ready
//   in_data    : input pixel, lane c = in_data[c*DATA_W +: DATA_W]
//   out_valid  : output beat valid
//   out_ready  : downstream accept
//   out_data   : output pixel (registered)
//   out_eol    : output beat is the last column of a row
//   out_eof    : output beat is the last beat of the frame
//   busy       : FSM not IDLE
//   frame_done : one-cycle pulse after the final beat handshakes
// ----------------------------------------------------------------------------
module input_pad_stream #(
  parameter int                DATA_W      = 32,
  parameter int                IN_W        = 7,
  parameter int                IN_H        = 7,
  parameter int                FILTER_SIZE = 3,
  parameter int                CHANNELS    = 1,
  parameter int                PAD_MODE    = 0,
  parameter logic [DATA_W-1:0] PAD_VALUE   = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_eol,
  output logic                         out_eof,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int OUT_W = IN_W + ((FILTER_SIZE - (IN_W % FILTER_SIZE)) % FILTER_SIZE);
  localparam int OUT_H = IN_H + ((FILTER_SIZE - (IN_H % FILTER_SIZE)) % FILTER_SIZE);
  localparam int PIX_W = CHANNELS * DATA_W;
  localparam int COL_W = $clog2(OUT_W + 1);
  localparam int ROW_W = $clog2(OUT_H + 1);
  localparam int LB_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [COL_W-1:0] IN_W_M1  = COL_W'(IN_W - 1);
  localparam logic [COL_W-1:0] OUT_W_M1 = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0] IN_H_M1  = ROW_W'(IN_H - 1);
  localparam logic [ROW_W-1:0] OUT_H_M1 = ROW_W'(OUT_H - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PASS    = 3'd1;
  localparam logic [2:0] S_PAD_COL = 3'd2;
  localparam logic [2:0] S_PAD_ROW = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  logic [2:0]       r_state;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_out_valid;
  logic [PIX_W-1:0] r_out_data;
  logic             r_out_eol;
  logic             r_out_eof;
  logic             r_frame_done;

  logic             w_adv;
  logic             w_out_fire;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_eol;
  logic             w_eof;
  logic [PIX_W-1:0] w_pad_const;
  logic [PIX_W-1:0] w_pad_col;
  logic [PIX_W-1:0] w_pad_row;
  logic [LB_AW-1:0] w_lb_idx;

  logic [2:0]       w_state_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic [COL_W-1:0] w_col_nxt;
  logic             w_load;
  logic [PIX_W-1:0] w_load_data;
  logic             w_done;

  logic [2:0]       w_eor_state;
  logic [ROW_W-1:0] w_eor_row;

  // The output register may take a new beat only when empty or being drained,
  // and never while paused.
  assign w_adv       = (~r_out_valid | out_ready) & en;
  assign w_out_fire  = r_out_valid & out_ready & en;
  assign w_in_ready  = (r_state == S_PASS) & w_adv;
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_eol       = (r_col == OUT_W_M1);
  assign w_eof       = w_eol & (r_row == OUT_H_M1);
  assign w_pad_const = {CHANNELS{PAD_VALUE}};
  assign w_lb_idx    = r_col[LB_AW-1:0];

  generate
    if (PAD_MODE == 1) begin : g_replicate
      logic [PIX_W-1:0] r_edge;
      logic [PIX_W-1:0] r_line_buf [OUT_W];

      // Edge register: last accepted pixel, replicated across the pad columns.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_edge <= '0;
        end else if (w_in_fire) begin
          r_edge <= in_data;
        end
      end

      // Line buffer captures every emitted beat of the last input row, pad
      // columns included, so pad rows can replay it column by column.
      always_ff @(posedge clk) begin
        if (w_load && (r_row == IN_H_M1) &&
            ((r_state == S_PASS) || (r_state == S_PAD_COL))) begin
          r_line_buf[w_lb_idx] <= w_load_data;
        end
      end

      assign w_pad_col = r_edge;
      assign w_pad_row = r_line_buf[w_lb_idx];
    end else begin : g_constant
      assign w_pad_col = w_pad_const;
      assign w_pad_row = w_pad_const;
    end
  endgenerate

  // Where the FSM goes after the last column of a row has been emitted.
  always_comb begin
    w_eor_state = S_DRAIN;
    w_eor_row   = r_row;
    if (r_row != IN_H_M1) begin
      w_eor_state = S_PASS;
      w_eor_row   = r_row + ROW_W'(1);
    end else if (OUT_H > IN_H) begin
      w_eor_state = S_PAD_ROW;
      w_eor_row   = r_row + ROW_W'(1);
    end else begin
      w_eor_state = S_DRAIN;
      w_eor_row   = r_row;
    end
  end

  // FSM next-state, counter update and output-register load selection.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_load      = 1'b0;
    w_load_data = r_out_data;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_PASS;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PASS: begin
        if (w_in_fire) begin
          w_load      = 1'b1;
          w_load_data = in_data;
          if (r_col == IN_W_M1) begin
            if (OUT_W > IN_W) begin
              w_state_nxt = S_PAD_COL;
              w_col_nxt   = r_col + COL_W'(1);
            end else begin
              w_state_nxt = w_eor_state;
              w_row_nxt   = w_eor_row;
              w_col_nxt   = '0;
            end
          end else begin
            w_col_nxt = r_col + COL_W'(1);
          end
        end else begin
          w_load = 1'b0;
        end
      end
      S_PAD_COL: begin
        if (w_adv) begin
          w_load      = 1'b1;
          w_load_data = w_pad_col;
          if (r_col == OUT_W_M1) begin
            w_state_nxt = w_eor_state;
            w_row_nxt   = w_eor_row;
            w_col_nxt   = '0;
          end else begin
            w_col_nxt = r_col + COL_W'(1);
          end
        end else begin
          w_load = 1'b0;
        end
      end
      S_PAD_ROW: begin
        if (w_adv) begin
          w_load      = 1'b1;
          w_load_data = w_pad_row;
          if (r_col == OUT_W_M1) begin
            w_col_nxt = '0;
            if (r_row == OUT_H_M1) begin
              w_state_nxt = S_DRAIN;
            end else begin
              w_row_nxt = r_row + ROW_W'(1);
            end
          end else begin
            w_col_nxt = r_col + COL_W'(1);
          end
        end else begin
          w_load = 1'b0;
        end
      end
      S_DRAIN: begin
        // Only the final (eof) beat can be sitting in the output register here.
        if (w_out_fire && r_out_eof) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and row/column counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_frame_done <= w_done;
    end
  end

  // Output register: holds its beat stable until it can advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_out_data <= w_load_data;
        r_out_eol  <= w_eol;
        r_out_eof  <= w_eof;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_eol    = r_out_eol;
  assign out_eof    = r_out_eof;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_input_pad_stream.sv
// ----------------------------------------------------------------------------
// tb_input_pad_stream
//   Directed bench for input_pad_stream. Three instances share one stimulus
//   port set, selected by 'sel':
//     0 : defaults (7x7, 1 lane, constant pad 0)
//     1 : 7x7, 2 lanes, replicate pad
//     2 : 6x6, 1 lane, constant pad (aligned, pure pass-through)
// ----------------------------------------------------------------------------
module tb_input_pad_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_en = 1'b0;
  logic        s_in_valid = 1'b0;
  logic [63:0] s_in_data = 64'd0;
  logic        s_out_ready = 1'b0;
  int          sel = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic        a_en, a_iv, a_ir, a_ov, a_eol, a_eof, a_busy, a_fd, a_or;
  logic [31:0] a_od;
  logic        b_en, b_iv, b_ir, b_ov, b_eol, b_eof, b_busy, b_fd, b_or;
  logic [63:0] b_od;
  logic        c_en, c_iv, c_ir, c_ov, c_eol, c_eof, c_busy, c_fd, c_or;
  logic [31:0] c_od;

  assign a_en = s_en & (sel == 0);
  assign a_iv = s_in_valid & (sel == 0);
  assign a_or = s_out_ready & (sel == 0);
  assign b_en = s_en & (sel == 1);
  assign b_iv = s_in_valid & (sel == 1);
  assign b_or = s_out_ready & (sel == 1);
  assign c_en = s_en & (sel == 2);
  assign c_iv = s_in_valid & (sel == 2);
  assign c_or = s_out_ready & (sel == 2);

  input_pad_stream u_a (
    .clk(clk), .reset(reset), .en(a_en), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(s_in_data[31:0]), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .out_eol(a_eol), .out_eof(a_eof), .busy(a_busy), .frame_done(a_fd)
  );

  input_pad_stream #(.CHANNELS(2), .PAD_MODE(1)) u_b (
    .clk(clk), .reset(reset), .en(b_en), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(s_in_data), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .out_eol(b_eol), .out_eof(b_eof), .busy(b_busy), .frame_done(b_fd)
  );

  input_pad_stream #(.IN_W(6), .IN_H(6)) u_c (
    .clk(clk), .reset(reset), .en(c_en), .in_valid(c_iv), .in_ready(c_ir),
    .in_data(s_in_data[31:0]), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
    .out_eol(c_eol), .out_eof(c_eof), .busy(c_busy), .frame_done(c_fd)
  );

  logic        m_ir, m_ov, m_eol, m_eof, m_busy, m_fd;
  logic [63:0] m_od;

  always_comb begin
    m_ir = a_ir; m_ov = a_ov; m_eol = a_eol; m_eof = a_eof; m_busy = a_busy; m_fd = a_fd;
    m_od = {32'd0, a_od};
    if (sel == 1) begin
      m_ir = b_ir; m_ov = b_ov; m_eol = b_eol; m_eof = b_eof; m_busy = b_busy; m_fd = b_fd;
      m_od = b_od;
    end else if (sel == 2) begin
      m_ir = c_ir; m_ov = c_ov; m_eol = c_eol; m_eof = c_eof; m_busy = c_busy; m_fd = c_fd;
      m_od = {32'd0, c_od};
    end
  end

  // Input pixel for pattern pt at (r,c).
  function automatic logic [63:0] in_pix(input int pt, input int r, input int c);
    logic [63:0] v;
    v = 64'd0;
    case (pt)
      0: v[31:0] = 32'd3;
      1: begin v[31:0] = 32'd3; v[63:32] = 32'(r * 16 + c); end
      2: v[31:0] = 32'(r * 16 + c);
      3: begin v[31:0] = 32'd3; v[63:32] = 32'(r * 9 + c); end
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  // Expected padded output pixel.
  function automatic logic [63:0] exp_pix(input int pt, input int md, input int iw,
                                          input int ih, input int r, input int c);
    int rr, cc;
    if (r < ih && c < iw) return in_pix(pt, r, c);
    if (md == 0) return 64'd0;
    rr = (r < ih) ? r : ih - 1;
    cc = (c < iw) ? c : iw - 1;
    return in_pix(pt, rr, cc);
  endfunction

  task automatic check_idle_outputs(input string nm);
    n_checks++;
    if (m_ov !== 1'b0 || m_od !== 64'd0 || m_eol !== 1'b0 || m_eof !== 1'b0 ||
        m_ir !== 1'b0 || m_busy !== 1'b0 || m_fd !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got ov=%b od=%h eol=%b eof=%b ir=%b busy=%b fd=%b, expected all 0",
               nm, m_ov, m_od, m_eol, m_eof, m_ir, m_busy, m_fd);
    end
  endtask

  // Drives one frame and checks every output beat, stall stability, pause
  // behaviour, refusal of extra input and the frame_done pulse.
  task automatic run_frame(input int s, input int iw, input int ih, input int ow,
                           input int oh, input int md, input int pt, input int rnd,
                           input int abort_at, input int pause_in, input string nm);
    int in_idx, out_idx, cyc, fd_cnt, pause_left, total, n_in;
    bit pend, paused, aborted;
    logic [63:0] pend_d, exp_d;
    logic pend_eol, pend_eof, exp_eol, exp_eof;
    total = ow * oh; n_in = iw * ih;
    in_idx = 0; out_idx = 0; cyc = 0; fd_cnt = 0; pause_left = 0;
    pend = 1'b0; paused = 1'b0; aborted = 1'b0;
    pend_d = 64'd0; pend_eol = 1'b0; pend_eof = 1'b0;
    sel = s;
    while (out_idx < total && cyc < 3000 && !aborted) begin
      @(negedge clk);
      cyc++;
      if (m_fd === 1'b1) fd_cnt++;
      if (pend) begin
        n_checks++;
        if (m_ov !== 1'b1 || m_od !== pend_d || m_eol !== pend_eol || m_eof !== pend_eof) begin
          n_fail++;
          $display("FAIL %s stall-hold beat %0d: got v=%b d=%h, required v=1 d=%h",
                   nm, out_idx, m_ov, m_od, pend_d);
        end
      end
      if (pause_in >= 0 && !paused && in_idx == pause_in) begin
        pause_left = 10;
        paused = 1'b1;
      end
      if (pause_left > 0) begin
        s_en = 1'b0; s_out_ready = 1'b0; pause_left--;
      end else begin
        s_en = 1'b1;
        s_out_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (in_idx < n_in) begin
        s_in_valid = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        s_in_data  = in_pix(pt, in_idx / iw, in_idx % iw);
      end else begin
        s_in_valid = 1'b1;
        s_in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      #1;
      if (!s_en || in_idx >= n_in) begin
        n_checks++;
        if (m_ir !== 1'b0) begin
          n_fail++;
          $display("FAIL %s in_ready (en=%b in_idx=%0d): got %b, required 0", nm, s_en, in_idx, m_ir);
        end
      end
      if (s_in_valid && m_ir === 1'b1 && in_idx < n_in) in_idx++;
      if (m_ov === 1'b1 && s_out_ready && s_en) begin
        exp_d   = exp_pix(pt, md, iw, ih, out_idx / ow, out_idx % ow);
        exp_eol = ((out_idx % ow) == ow - 1);
        exp_eof = (out_idx == total - 1);
        n_checks++;
        if (m_od !== exp_d) begin
          n_fail++;
          $display("FAIL %s data beat %0d (r%0d c%0d): got %h, required %h",
                   nm, out_idx, out_idx / ow, out_idx % ow, m_od, exp_d);
        end
        n_checks++;
        if (m_eol !== exp_eol || m_eof !== exp_eof) begin
          n_fail++;
          $display("FAIL %s eol/eof beat %0d: got %b/%b, required %b/%b",
                   nm, out_idx, m_eol, m_eof, exp_eol, exp_eof);
        end
        out_idx++;
        pend = 1'b0;
      end else begin
        pend = m_ov; pend_d = m_od; pend_eol = m_eol; pend_eof = m_eof;
      end
      if (abort_at >= 0 && out_idx == abort_at) aborted = 1'b1;
    end
    if (cyc >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got %0d beats, required %0d", nm, out_idx, total);
    end
    if (!aborted) begin
      @(negedge clk);
      s_en = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
      #1;
      if (m_fd === 1'b1) fd_cnt++;
      n_checks++;
      if (fd_cnt != 1) begin
        n_fail++;
        $display("FAIL %s frame_done count: got %0d, required 1", nm, fd_cnt);
      end
      n_checks++;
      if (m_busy !== 1'b0 || m_ov !== 1'b0) begin
        n_fail++;
        $display("FAIL %s post-frame busy/out_valid: got %b/%b, required 0/0", nm, m_busy, m_ov);
      end
      @(negedge clk);
      n_checks++;
      if (m_fd !== 1'b0 || m_ov !== 1'b0) begin
        n_fail++;
        $display("FAIL %s frame_done/out_valid after pulse: got %b/%b, required 0/0", nm, m_fd, m_ov);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check_idle_outputs("reset_state");
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pad_const;
    run_frame(0, 7, 7, 9, 9, 0, 0, 0, -1, -1, "pad_const");
  endtask

  task automatic test_pad_replicate;
    run_frame(1, 7, 7, 9, 9, 1, 1, 0, -1, -1, "pad_replicate");
  endtask

  task automatic test_aligned;
    run_frame(2, 6, 6, 6, 6, 0, 2, 0, -1, -1, "aligned");
  endtask

  task automatic test_random_stall;
    run_frame(0, 7, 7, 9, 9, 0, 0, 1, -1, -1, "random_stall");
  endtask

  task automatic test_reset_mid_frame;
    run_frame(0, 7, 7, 9, 9, 0, 0, 0, 40, -1, "reset_mid_abort");
    @(negedge clk);
    reset = 1'b0; s_en = 1'b1; s_in_valid = 1'b1; s_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_idle_outputs("reset_mid");
      @(negedge clk);
    end
    s_en = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    run_frame(0, 7, 7, 9, 9, 0, 0, 0, -1, -1, "after_reset");
  endtask

  task automatic test_multilane_pause;
    run_frame(1, 7, 7, 9, 9, 1, 3, 0, -1, 10, "multilane_pause");
  endtask

  task automatic test_back_to_back;
    run_frame(2, 6, 6, 6, 6, 0, 2, 0, -1, -1, "b2b_first");
    run_frame(2, 6, 6, 6, 6, 0, 2, 1, -1, -1, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_pad_const();
    test_pad_replicate();
    test_aligned();
    test_random_stall();
    test_reset_mid_frame();
    test_multilane_pause();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
